mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: TIMEOUT, 1024, cycles BUSY may wait for m_rvalid before abort.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Ports: i_req in 1, i_addr in AW, i_gnt out 1, i_rvalid out 1, i_rdata out XLEN. Instruction-fetch requester, read-only.
REQ-007 Ports: d_req in 1, d_we in 1, d_addr in AW, d_wdata in XLEN, d_wstrb in XLEN/8, d_gnt out 1, d_rvalid out 1, d_rdata out XLEN. Data requester.
REQ-008 Ports: m_req out 1, m_we out 1, m_addr out AW, m_wdata out XLEN, m_wstrb out XLEN/8, m_ready in 1, m_rvalid in 1, m_rdata in XLEN. Shared single-port memory.
REQ-009 Port: err  out  1  sticky timeout flag.

Function
REQ-010 The block SHALL share one memory port between I and D, with at most one outstanding transaction.
REQ-011 FSM states SHALL be IDLE (no outstanding transaction) and BUSY (awaiting m_rvalid).
REQ-012 A grant SHALL occur in any cycle where the FSM is IDLE, or BUSY with m_rvalid=1, at least one requester asserts req, and m_ready=1.
REQ-013 In a grant cycle, m_req=1, m_* SHALL combinationally mirror the winner, and exactly one of i_gnt/d_gnt SHALL be 1.
REQ-014 An I grant SHALL drive m_we=0, m_wdata=0, m_wstrb=0.
REQ-015 A sole requester SHALL win. When both request, the winner SHALL be the requester not granted in the previous contested grant (round-robin; last_d bit).
REQ-016 Requesters SHALL hold req and payload until gnt; the arbiter SHALL never grant without req.
REQ-017 On a grant, the owner (I/D) SHALL be registered, and the FSM SHALL go to or stay in BUSY.
REQ-018 In BUSY with m_rvalid=1, the owner's rvalid SHALL pulse 1 for that cycle. Without a new grant, the FSM SHALL return to IDLE. With a new grant, it SHALL stay BUSY for back-to-back operation.
REQ-019 i_rdata and d_rdata SHALL both equal m_rdata at all times; only rvalid qualifies them.
REQ-020 Writes SHALL receive an rvalid response like reads; rdata is don't-care.
REQ-021 m_rvalid in IDLE SHALL be ignored: no rvalid output, no state change.
REQ-022 If m_ready=0, there SHALL be no gnt and no m_req; the round-robin bit SHALL be unchanged.
REQ-023 A wait counter SHALL clear on entering BUSY and increment each BUSY cycle without m_rvalid.
REQ-024 When the wait counter reaches TIMEOUT-1 without m_rvalid, the next edge SHALL set err=1, pulse the owner's rvalid once with rdata don't-care, and return the FSM to IDLE.
REQ-025 err SHALL be cleared only by reset.
REQ-026 Latency: gnt in cycle N, response in the first cycle with m_rvalid=1 after N (≥N+1).

Reset
REQ-027 While reset=0 at a clock edge, state SHALL be IDLE, owner=I, last_d=0 (first contested grant goes to D), wait counter=0, and err=0.
REQ-028 While reset=0, all gnt, rvalid and m_req outputs SHALL be 0 regardless of inputs.
REQ-029 Reset asserted in BUSY SHALL abandon the outstanding transaction without any rvalid pulse. A stale m_rvalid after reset SHALL be ignored per REQ-021.

Structure
REQ-030 State encoding (IDLE/BUSY) and owner encoding (OWN_I/OWN_D) SHALL live in the shared constants header alongside D_XLEN.
REQ-031 XLEN SHALL default from D_XLEN.
REQ-032 The round-robin pick SHALL be a sub-module rr_arb2 (2 requests, last-winner input, one-hot grant); the rest SHALL be flat.

Verification
REQ-033 Sole I request to addr 0x1000, m_ready=1, m_rvalid at N+1 with rdata 0x00000013 -> i_gnt at N, i_rvalid at N+1 with i_rdata 0x00000013, d_rvalid=0.
REQ-034 After reset, both requesting continuously for 4 grants -> grant order D,I,D,I.
REQ-035 D write to addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF -> m_we=1 and payload mirrored in the grant cycle; d_rvalid on m_rvalid.
REQ-036 m_rvalid in the same cycle as a pending I request -> D's rvalid and i_gnt occur in the same cycle; the FSM stays BUSY.
REQ-037 TIMEOUT=8, no m_rvalid after D grant -> err=1 and d_rvalid pulse exactly 8 cycles after grant; FSM back in IDLE; err holds until reset.
REQ-038 reset=0 mid-BUSY, then m_rvalid=1 after release -> no rvalid outputs; err=0; next contested grant goes to D.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the I/D memory arbiter: default data width,
// FSM state encoding and transaction-owner encoding.
package mem_arbiter_pkg;

  localparam int D_XLEN = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Bit 0 is the instruction requester and bit 1
// the data requester. A sole requester always wins; on contention the side
// that did not win the previous contested grant is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_d,
  output logic [1:0] gnt
);

  // One-hot winner; on contention favour whoever lost last time
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_d ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch requester and
// a data requester, with at most one transaction outstanding. Responses are
// steered back to the registered owner; a stuck memory is aborted after
// TIMEOUT busy cycles and flagged on the sticky err output.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN    = D_XLEN,
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_wstrb,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              err
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  logic           last_d_q, last_d_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           err_q, err_d;

  logic       busy_resp;
  logic       timeout_hit;
  logic       can_grant;
  logic       grant_i;
  logic       grant_d;
  logic       resp;
  logic [1:0] arb_gnt;

  rr_arb2 u_rr_arb2 (
    .req    ({d_req, i_req}),
    .last_d (last_d_q),
    .gnt    (arb_gnt)
  );

  // Grant qualification, memory-port mirroring and response steering
  always_comb begin
    busy_resp   = (state_q == BUSY) && m_rvalid;
    timeout_hit = (state_q == BUSY) && !m_rvalid && (wait_q == WAIT_LAST);
    can_grant   = reset && m_ready && ((state_q == IDLE) || busy_resp);
    grant_i     = can_grant && arb_gnt[0];
    grant_d     = can_grant && arb_gnt[1];
    resp        = reset && (busy_resp || timeout_hit);

    i_gnt    = grant_i;
    d_gnt    = grant_d;
    m_req    = grant_i || grant_d;
    m_we     = grant_d && d_we;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    if (grant_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wstrb = d_wstrb;
    end else if (grant_i) begin
      m_addr  = i_addr;
    end

    i_rvalid = resp && (owner_q == OWN_I);
    d_rvalid = resp && (owner_q == OWN_D);
    i_rdata  = m_rdata;
    d_rdata  = m_rdata;
    err      = err_q;
  end

  // Next-state: a grant (re)enters BUSY, a response or timeout drops to IDLE
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d_d = last_d_q;
    wait_d   = wait_q;
    err_d    = err_q;
    if (grant_i || grant_d) begin
      state_d = BUSY;
      owner_d = grant_d ? OWN_D : OWN_I;
      wait_d  = '0;
      if (i_req && d_req) begin
        last_d_d = grant_d;
      end
    end else if (busy_resp) begin
      state_d = IDLE;
      wait_d  = '0;
    end else if (timeout_hit) begin
      state_d = IDLE;
      wait_d  = '0;
      err_d   = 1'b1;
    end else if (state_q == BUSY) begin
      wait_d = wait_q + WCW'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      last_d_q <= 1'b0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_d_q <= last_d_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter. The main process drives
// requesters and the memory side and pushes expected grants/responses;
// a negedge monitor pops and compares whenever a grant or rvalid appears.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gnt_exp_t;

  typedef struct {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } rsp_exp_t;

  gnt_exp_t gnt_q[$];
  rsp_exp_t rsp_q[$];

  mem_arbiter #(.XLEN(32), .AW(32), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .err      (err)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dws);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    d_wstrb = dws;
  endtask

  task automatic memDrive(input logic rdy, input logic rv, input logic [31:0] rd);
    m_ready  = rdy;
    m_rvalid = rv;
    m_rdata  = rd;
  endtask

  task automatic expectGrant(input logic is_d, input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
    gnt_exp_t g;
    g.is_d  = is_d;
    g.addr  = addr;
    g.we    = we;
    g.wdata = wdata;
    g.wstrb = wstrb;
    gnt_q.push_back(g);
  endtask

  task automatic expectRsp(input logic is_d, input logic chk, input logic [31:0] data);
    rsp_exp_t r;
    r.is_d = is_d;
    r.chk  = chk;
    r.data = data;
    rsp_q.push_back(r);
  endtask

  // Monitor: compare every observed grant and response against the scoreboard
  always @(negedge clk) begin
    gnt_exp_t g;
    rsp_exp_t r;
    if (reset === 1'b1) begin
      if (i_gnt || d_gnt || m_req) begin
        if (gnt_q.size() == 0) begin
          checkOutput("unexpected_grant", {29'd0, m_req, d_gnt, i_gnt}, 32'd0);
        end else begin
          g = gnt_q.pop_front();
          checkOutput("grant_onehot", {31'd0, i_gnt ^ d_gnt}, 32'd1);
          checkOutput("grant_winner_is_d", {31'd0, d_gnt}, {31'd0, g.is_d});
          checkOutput("grant_m_req", {31'd0, m_req}, 32'd1);
          checkOutput("grant_m_addr", m_addr, g.addr);
          checkOutput("grant_m_we", {31'd0, m_we}, {31'd0, g.we});
          checkOutput("grant_m_wdata", m_wdata, g.wdata);
          checkOutput("grant_m_wstrb", {28'd0, m_wstrb}, {28'd0, g.wstrb});
        end
      end
      if (i_rvalid || d_rvalid) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          checkOutput("rvalid_onehot", {31'd0, i_rvalid ^ d_rvalid}, 32'd1);
          checkOutput("rvalid_owner_is_d", {31'd0, d_rvalid}, {31'd0, r.is_d});
          if (r.chk) begin
            checkOutput("rdata", r.is_d ? d_rdata : i_rdata, r.data);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends with a summary
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Directed stimulus sequence
  initial begin
    reset = 1'b0;
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'h1234, 4'hF);
    memDrive(1'b1, 1'b1, 32'h0);
    cycle();
    cycle();
    peek();
    checkOutput("reset_gnts", {30'd0, d_gnt, i_gnt}, 32'd0);
    checkOutput("reset_m_req", {31'd0, m_req}, 32'd0);
    checkOutput("reset_rvalids", {30'd0, d_rvalid, i_rvalid}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    cycle();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b0, 32'h0);

    // Sole I fetch, response one cycle after grant
    expectGrant(1'b0, 32'h1000, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b0, 1'b1, 32'h0000_0013);
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    peek();
    checkOutput("i_fetch_gnt", {31'd0, i_gnt}, 32'd1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b1, 32'h0000_0013);
    peek();
    checkOutput("i_fetch_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd1);
    cycle();

    // Stray m_rvalid while idle must be ignored
    memDrive(1'b1, 1'b1, 32'hBAD0_0001);
    peek();
    checkOutput("idle_rvalid_ignored", {30'd0, d_rvalid, i_rvalid}, 32'd0);
    cycle();
    memDrive(1'b1, 1'b0, 32'h0);

    // Fresh reset, then continuous contention: order D, I, D, I
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    expectGrant(1'b1, 32'h200, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b1, 1'b1, 32'hA1);
    expectGrant(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b0, 1'b1, 32'hA2);
    expectGrant(1'b1, 32'h200, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b1, 1'b1, 32'hA3);
    expectGrant(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b0, 1'b1, 32'hA4);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    cycle();
    memDrive(1'b1, 1'b1, 32'hA1);
    peek();
    checkOutput("d_rvalid_with_i_gnt", {30'd0, d_rvalid, i_gnt}, 32'd3);
    cycle();
    memDrive(1'b1, 1'b1, 32'hA2);
    cycle();
    memDrive(1'b1, 1'b1, 32'hA3);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b1, 32'hA4);
    cycle();
    memDrive(1'b1, 1'b0, 32'h0);

    // Memory not ready: no grant, then D write wins the contested grant
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
    memDrive(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      peek();
      checkOutput("not_ready_no_grant", {29'd0, m_req, d_gnt, i_gnt}, 32'd0);
      cycle();
    end
    expectGrant(1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    expectRsp(1'b1, 1'b0, 32'h0);
    expectGrant(1'b0, 32'h104, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b0, 1'b1, 32'h55);
    memDrive(1'b1, 1'b0, 32'h0);
    peek();
    checkOutput("write_m_we", {31'd0, m_we}, 32'd1);
    cycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b1, 32'h77);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b1, 32'h55);
    cycle();
    memDrive(1'b1, 1'b0, 32'h0);

    // Timeout: no m_rvalid after a D grant
    expectGrant(1'b1, 32'h3000, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      peek();
      if (k < 8) begin
        checkOutput("timeout_no_early_rvalid", {31'd0, d_rvalid}, 32'd0);
      end else begin
        checkOutput("timeout_rvalid_at_8", {31'd0, d_rvalid}, 32'd1);
      end
      cycle();
    end
    memDrive(1'b1, 1'b1, 32'hBAD0_0002);
    peek();
    checkOutput("timeout_err_set", {31'd0, err}, 32'd1);
    checkOutput("timeout_back_to_idle", {30'd0, d_rvalid, i_rvalid}, 32'd0);
    cycle();
    memDrive(1'b1, 1'b0, 32'h0);
    cycle();
    cycle();
    peek();
    checkOutput("err_sticky", {31'd0, err}, 32'd1);
    cycle();

    // Reset while BUSY abandons the transaction and restores arbitration
    expectGrant(1'b1, 32'h4000, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
    peek();
    checkOutput("err_holds_across_grant", {31'd0, err}, 32'd1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    peek();
    checkOutput("reset_busy_err_cleared", {31'd0, err}, 32'd0);
    checkOutput("reset_busy_outputs", {27'd0, m_req, d_gnt, i_gnt, d_rvalid, i_rvalid}, 32'd0);
    cycle();
    reset = 1'b1;
    memDrive(1'b1, 1'b1, 32'h99);
    peek();
    checkOutput("stale_rvalid_ignored", {30'd0, d_rvalid, i_rvalid}, 32'd0);
    cycle();
    memDrive(1'b1, 1'b0, 32'h0);
    expectGrant(1'b1, 32'h5000, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b1, 1'b1, 32'h66);
    expectGrant(1'b0, 32'h500, 1'b0, 32'h0, 4'h0);
    expectRsp(1'b0, 1'b1, 32'h67);
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h5000, 32'h0, 4'h0);
    peek();
    checkOutput("post_reset_contest_d", {30'd0, d_gnt, i_gnt}, 32'd2);
    cycle();
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b1, 32'h66);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memDrive(1'b1, 1'b1, 32'h67);
    cycle();
    memDrive(1'b1, 1'b0, 32'h0);
    cycle();
    cycle();

    checkOutput("grant_queue_drained", gnt_q.size(), 32'd0);
    checkOutput("rsp_queue_drained", rsp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
